// File: rtl/cpu_sequencer_pkg.sv
// Shared types and decode constants for the 9-bit CPU instruction sequencer.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        FETCH,
        EXEC,
        MEMW,
        HALT
    } seq_state_t;

    // reg_op codes the instruction decoder matches to drive is_load/is_store/is_halt
    localparam logic [3:0] REG_OP_LOAD  = 4'd8;
    localparam logic [3:0] REG_OP_STORE = 4'd9;
    localparam logic [3:0] REG_OP_HALT  = 4'd15;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Memory-wait watchdog: counts MEMW cycles without an ack and flags the last allowed one.
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] wait_cnt;

    // expired marks the final permitted wait cycle, so the sequencer leaves on that edge
    assign expired = (wait_cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expired) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: steps the core through boot/fetch/execute/memory-wait and
// emits commit strobes, the data-memory handshake, halt status and retire count.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             mem_ack,
    output logic             boot_ld,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_t state;
    seq_state_t next_state;
    logic       load_q;
    logic       store_q;
    logic       retire;
    logic       timeout;
    logic       wait_clear;
    logic       wait_en;
    logic       expired;

    seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wait_clear),
        .enable (wait_en),
        .expired(expired)
    );

    assign busy = (state != IDLE) && (state != HALT);
    assign done = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_cnt   <= '0;
            err_timeout <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            state <= next_state;
            // Entering BOOT starts a fresh run, so the count and error are visible as 0 in BOOT
            if (next_state == BOOT) begin
                instr_cnt   <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (retire && (instr_cnt != '1)) begin
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
                if (timeout) begin
                    err_timeout <= 1'b1;
                end
            end
            if (state == EXEC) begin
                load_q  <= is_load;
                store_q <= is_store;
            end
        end
    end

    always_comb begin
        next_state = state;
        boot_ld    = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        timeout    = 1'b0;
        wait_clear = 1'b0;
        wait_en    = 1'b0;

        case (state)
            IDLE: begin
                if (start) next_state = BOOT;
            end
            BOOT: begin
                boot_ld    = 1'b1;
                next_state = FETCH;
            end
            FETCH: begin
                if (start) begin
                    next_state = BOOT;
                end else begin
                    ir_we      = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (start) begin
                    next_state = BOOT;
                end else if (is_halt) begin
                    next_state = HALT;
                end else if (is_load || is_store) begin
                    mem_req    = 1'b1;
                    mem_we     = is_store;
                    wait_clear = 1'b1;
                    next_state = MEMW;
                end else begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            MEMW: begin
                // A restart abandons the transaction: the request drops in this very cycle
                if (start) begin
                    next_state = BOOT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = store_q;
                    if (mem_ack) begin
                        rf_we      = load_q;
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else if (expired) begin
                        timeout    = 1'b1;
                        next_state = HALT;
                    end else begin
                        wait_en = 1'b1;
                    end
                end
            end
            HALT: begin
                if (start) next_state = BOOT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
